matmul_sequencer: RTL and testbench
===================================

Name: matmul_sequencer

Overview:
- Control FSM for the matrix-multiply datapath: walks output element (i,j) and reduction index k over DIM x DIM operands, row-major.
- Drives operand read addresses, accumulator clear/enable and result write strobe.
- Sits between the top-level start/done handshake and the MAC datapath.
- Supports a stall input for operand-memory back-pressure and a synchronous abort.

Parameters:
DIM, 4, matrix dimension; power of two, >= 2
IDX_W, 2, index width = log2(DIM)
ADDR_W, 4, operand/result address width = 2*IDX_W

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  begin a multiply; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE, no done
stall  input  1  freeze MAC progress this cycle
a_addr  output  ADDR_W  A operand address = {i,k}
b_addr  output  ADDR_W  B operand address = {k,j}
c_addr  output  ADDR_W  C result address = {i,j}
acc_clr  output  1  clear accumulator
acc_en  output  1  accumulate current product
c_wr  output  1  write accumulator to C[c_addr]
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, async): state=IDLE, i=j=k=0; all strobes, busy and done 0; addresses 0.
- Outputs decode from registered state and registered i/j/k; addresses are concatenations, so {i,k} = i*DIM+k.
- IDLE: busy=0. start=1 -> CLR. Else hold.
- CLR: acc_clr=1 for exactly one cycle, k=0 -> MAC.
- MAC: acc_en = !stall; a_addr/b_addr valid.
  - stall=1: k, state and addresses hold; acc_en=0.
  - stall=0 and k<DIM-1: k++.
  - stall=0 and k==DIM-1: -> WR; k stays DIM-1.
- WR: c_wr=1 for one cycle, c_addr={i,j}.
  - i==j==DIM-1: -> DONE.
  - Otherwise j++; on j wrap to 0, i++. -> CLR.
- DONE: done=1 for one cycle, busy=1; i=j=k cleared -> IDLE.
- start outside IDLE is ignored. start in DONE is not queued.
- abort=1 in any non-IDLE state: next cycle IDLE, indices 0, no c_wr and no done. abort has priority over stall and all transitions. abort in IDLE has no effect.
- stall is ignored outside MAC. CLR and WR always take exactly one cycle.
- Latency with no stall: start sampled at cycle 0 -> first acc_clr at cycle 1.
  - Each element takes DIM+2 cycles.
  - done at cycle DIM*DIM*(DIM+2)+1 (97 for DIM=4).
  - Each stalled MAC cycle adds 1.
- Async reset mid-run: immediate return to reset values; the next start begins again at (0,0).

Decomposition:
- Shared package matmul_pkg:
  - state encoding localparams IDLE/CLR/MAC/WR/DONE (3-bit)
  - DIM/IDX_W defaults, shared with the datapath
- One sub-module, wrap_counter: IDX_W-bit counter with clear, enable, terminal-count flag (count==DIM-1) and wrap to 0.
  - Instantiated three times (k, j, i); i and j are chained via terminal count.

Test Plan:
- Reset with reset=0 mid-MAC at (1,2,k=1) -> all outputs 0 and state IDLE within the same cycle; after release, start -> acc_clr at the next cycle with a_addr=0.
- DIM=4, start pulse, no stall:
  - exactly 16 acc_clr, 64 acc_en and 16 c_wr pulses
  - c_addr sequence 0,1,...,15
  - a_addr for element (2,3) = 8,9,10,11 and b_addr = 3,7,11,15
  - done at cycle 97; busy high in cycles 1..97
- Stall held 3 cycles at k=2 of element (0,0) -> addresses frozen at a=2, b=8; acc_en=0 during the stall; done at cycle 100.
- abort asserted during WR of element 5 -> no c_wr that cycle, IDLE next cycle, done never pulses; a subsequent start completes normally in 97 cycles.
- start held high continuously -> after the done pulse the sequencer returns to IDLE, then restarts on the following cycle; start pulses while busy do not perturb the sequence.
- stall=1 during CLR and WR -> no effect; timing is unchanged versus the no-stall run.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer and its datapath.
package matmul_pkg;

    // Default matrix dimension and derived index/address widths
    localparam int unsigned DIM_DEF    = 4;
    localparam int unsigned IDX_W_DEF  = 2;
    localparam int unsigned ADDR_W_DEF = 2 * IDX_W_DEF;

    // Sequencer control states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        MAC  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Index counter: counts 0..DIM-1 and wraps, with synchronous clear and a
// terminal-count flag at DIM-1.
module wrap_counter
    import matmul_pkg::*;
#(
    parameter int unsigned DIM   = DIM_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [IDX_W-1:0] count,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIM - 1);

    assign tc = (count == LAST);

    // Clear beats enable; enable at the terminal count wraps back to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Control FSM for the matrix-multiply datapath: walks output element (i,j)
// row-major and reduction index k, driving operand addresses, accumulator
// control and the result write strobe.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned DIM    = DIM_DEF,
    parameter int unsigned IDX_W  = IDX_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              stall,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              c_wr,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [IDX_W-1:0] i_idx, j_idx, k_idx;
    logic             i_tc, j_tc, k_tc;
    logic             last_elem;
    logic             kill;
    logic             k_clr, k_en;
    logic             ij_clr, j_en, i_en;

    assign last_elem = i_tc & j_tc;
    // Abort only acts once a multiply is in flight
    assign kill      = abort & (state != IDLE);

    // k restarts at every element; i/j only restart after completion or abort
    assign k_clr  = kill | (state == CLR) | (state == DONE);
    assign k_en   = (state == MAC) & ~stall & ~k_tc;
    assign ij_clr = kill | (state == DONE);
    assign j_en   = (state == WR) & ~last_elem;
    assign i_en   = (state == WR) & j_tc & ~last_elem;

    wrap_counter #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_k_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (k_clr),
        .en    (k_en),
        .count (k_idx),
        .tc    (k_tc)
    );

    wrap_counter #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_j_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ij_clr),
        .en    (j_en),
        .count (j_idx),
        .tc    (j_tc)
    );

    wrap_counter #(
        .DIM   (DIM),
        .IDX_W (IDX_W)
    ) u_i_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (ij_clr),
        .en    (i_en),
        .count (i_idx),
        .tc    (i_tc)
    );

    // Sequencer state: abort overrides every transition, stall only holds MAC
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else if (kill) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state <= CLR;
                CLR:     state <= MAC;
                MAC:     if (!stall && k_tc) state <= WR;
                WR:      state <= last_elem ? DONE : CLR;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Addresses are index concatenations, i.e. row*DIM + col
    assign a_addr = {i_idx, k_idx};
    assign b_addr = {k_idx, j_idx};
    assign c_addr = {i_idx, j_idx};

    // Strobes decode from registered state; an abort cycle suppresses write and done
    assign acc_clr = (state == CLR);
    assign acc_en  = (state == MAC) & ~stall;
    assign c_wr    = (state == WR) & ~abort;
    assign done    = (state == DONE) & ~abort;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer (DIM=4): cycle counts, address
// sequences, stall, abort, held start and asynchronous reset.
module tb_matmul_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stall = 1'b0;
    logic [3:0] a_addr, b_addr, c_addr;
    logic       acc_clr, acc_en, c_wr, busy, done;

    int total = 0;
    int bad   = 0;

    // Per-run observations
    int         n_clr, n_en, n_wr, done_cyc, busy_low, last_cyc, n_done;
    logic [3:0] wr_q[$];
    logic [3:0] en_a[$];
    logic [3:0] en_b[$];

    matmul_sequencer dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .abort   (abort),
        .stall   (stall),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .c_addr  (c_addr),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .c_wr    (c_wr),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start a multiply (start sampled at cycle 0) and observe cycles 1..budget.
    // Ends on done, on the cycle after an abort, or when the budget runs out.
    task automatic run_seq(input int stall_from, input int stall_n, input bit stall_cw,
                           input int abort_at, input bit hold_start, input int budget);
        n_clr = 0; n_en = 0; n_wr = 0; done_cyc = -1; busy_low = 0; last_cyc = 0;
        wr_q.delete(); en_a.delete(); en_b.delete();
        @(posedge clk); #1;
        start = 1'b1;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(posedge clk); #1;
            if (!hold_start) start = 1'b0;
            stall = (cyc >= stall_from && cyc < stall_from + stall_n) ||
                    (stall_cw && ((cyc - 1) % 6 == 0 || (cyc - 1) % 6 == 5));
            abort = (cyc == abort_at);
            #1;
            if (acc_clr) n_clr++;
            if (acc_en) begin
                n_en++;
                en_a.push_back(a_addr);
                en_b.push_back(b_addr);
            end
            if (c_wr) begin
                n_wr++;
                wr_q.push_back(c_addr);
            end
            if (stall_n > 0 && cyc >= stall_from && cyc < stall_from + stall_n) begin
                check("stall_a_addr", a_addr, 2);
                check("stall_b_addr", b_addr, 8);
                check("stall_acc_en", acc_en, 0);
            end
            if (cyc == abort_at) check("abort_c_wr", c_wr, 0);
            if (!busy) busy_low++;
            last_cyc = cyc;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_at > 0 && cyc == abort_at + 1) break;
        end
        stall = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_addrs", {a_addr, b_addr, c_addr}, 0);
        check("rst_strobes", {acc_clr, acc_en, c_wr, busy, done}, 0);
        #5 reset = 1'b1;

        // Plain run, no stall
        run_seq(0, 0, 0, 0, 0, 200);
        check("plain_done_cyc", done_cyc, 97);
        check("plain_n_clr", n_clr, 16);
        check("plain_n_en", n_en, 64);
        check("plain_n_wr", n_wr, 16);
        check("plain_busy_low", busy_low, 0);
        for (int e = 0; e < wr_q.size(); e++) check("plain_c_addr", wr_q[e], e);
        if (en_a.size() >= 48) begin
            for (int t = 0; t < 4; t++) begin
                check("elem23_a_addr", en_a[44 + t], 8 + t);
                check("elem23_b_addr", en_b[44 + t], 3 + 4 * t);
            end
        end
        @(posedge clk); #1;
        check("plain_idle_busy", busy, 0);
        check("plain_idle_done", done, 0);

        // Three stall cycles at k=2 of element (0,0)
        run_seq(4, 3, 0, 0, 0, 200);
        check("stall_done_cyc", done_cyc, 100);
        check("stall_n_en", n_en, 64);
        check("stall_n_wr", n_wr, 16);

        // Stall asserted only in CLR and WR cycles
        run_seq(0, 0, 1, 0, 0, 200);
        check("stallcw_done_cyc", done_cyc, 97);
        check("stallcw_n_clr", n_clr, 16);
        check("stallcw_n_en", n_en, 64);
        check("stallcw_n_wr", n_wr, 16);

        // Abort during WR of element 5 (cycle 36)
        run_seq(0, 0, 0, 36, 0, 200);
        check("abort_n_wr", n_wr, 5);
        check("abort_done_cyc", done_cyc, -1);
        check("abort_last_cyc", last_cyc, 37);
        check("abort_busy_after", busy, 0);
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        check("abort_quiet", n_done, 0);
        run_seq(0, 0, 0, 0, 0, 200);
        check("post_abort_done_cyc", done_cyc, 97);
        check("post_abort_n_wr", n_wr, 16);
        if (wr_q.size() > 0) check("post_abort_first_c", wr_q[0], 0);

        // Start held high throughout
        run_seq(0, 0, 0, 0, 1, 200);
        check("hold_done_cyc", done_cyc, 97);
        check("hold_n_wr", n_wr, 16);
        check("hold_n_clr", n_clr, 16);
        @(posedge clk); #1;
        check("hold_idle_busy", busy, 0);
        @(posedge clk); #1;
        check("hold_restart_clr", acc_clr, 1);
        check("hold_restart_busy", busy, 1);
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("hold_abort_busy", busy, 0);

        // Asynchronous reset in MAC of element (1,2) at k=1 (cycle 39)
        run_seq(0, 0, 0, 0, 0, 39);
        check("mid_a_addr", a_addr, 5);
        check("mid_b_addr", b_addr, 6);
        check("mid_acc_en", acc_en, 1);
        #1 reset = 1'b0;
        #1;
        check("async_rst_addrs", {a_addr, b_addr, c_addr}, 0);
        check("async_rst_strobes", {acc_clr, acc_en, c_wr, busy, done}, 0);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rerun_acc_clr", acc_clr, 1);
        check("rerun_a_addr", a_addr, 0);
        check("rerun_c_addr", c_addr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
